mem_port_arbiter: RTL

Shares the single unified instruction/data memory port between the fetch stage (IF) and the memory stage (MEM) of the 5-stage RISC-V pipeline. Sequences each access through a request/grant/response handshake with variable-latency memory. Produces stall_f and stall_m, which the hazard unit ORs into StallF and StallD/StallE/StallM. Data accesses have priority, with a bounded-starvation rule so that fetch always makes progress.

---
 rtl/mem_port_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared instruction/data memory port between fetch and data with bounded fetch starvation.
// Latency: request seen in IDLE -> mem_req next cycle -> ready one cycle after mem_rvalid; requesters stall until ready.
module mem_port_arbiter #(
  parameter int MAX_DM_GRANTS = 4,
  parameter int TIMEOUT       = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_wmask,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        stall_f,
  output logic        stall_m,
  output logic        bus_err
);

  localparam int GW = $clog2(MAX_DM_GRANTS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] GMAX  = GW'(MAX_DM_GRANTS);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_I  = 3'd1,
    REQ_D  = 3'd2,
    WAIT_I = 3'd3,
    WAIT_D = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          abort_q, abort_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_wmask_q, mem_wmask_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   dm_rdata_q, dm_rdata_d;
  logic          if_ready_q, if_ready_d;
  logic          dm_ready_q, dm_ready_d;
  logic          bus_err_q, bus_err_d;

  logic dm_win;
  logic if_win;
  logic tmo;
  logic fetch_live;

  assign dm_win     = dm_req && (!if_req || (gcnt_q < GMAX));
  assign if_win     = if_req && !dm_win;
  assign tmo        = (tcnt_q == TLAST);
  // A fetch that dropped if_req at any point during its transaction is dead even if if_req returns.
  assign fetch_live = if_req && !abort_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      gcnt_q      <= '0;
      tcnt_q      <= '0;
      abort_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gcnt_q      <= gcnt_d;
      tcnt_q      <= tcnt_d;
      abort_q     <= abort_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      bus_err_q   <= bus_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (dm_win)      state_d = REQ_D;
        else if (if_win) state_d = REQ_I;
      end
      REQ_I:  if (mem_gnt) state_d = WAIT_I;
      REQ_D:  if (mem_gnt) state_d = WAIT_D;
      WAIT_I: if (mem_rvalid || tmo) state_d = RESP;
      WAIT_D: if (mem_rvalid || tmo) state_d = RESP;
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    bus_err_d   = bus_err_q;
    abort_d     = abort_q;
    tcnt_d      = '0;
    gcnt_d      = if_req ? gcnt_q : '0;
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (dm_win) begin
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_wmask_d = dm_we ? dm_wmask : 4'b0000;
          if (if_req) gcnt_d = gcnt_q + GW'(1);
        end else if (if_win) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_wmask_d = 4'b0000;
          gcnt_d      = '0;
        end
      end
      REQ_I: begin
        if (!if_req)  abort_d   = 1'b1;
        if (mem_gnt)  mem_req_d = 1'b0;
      end
      REQ_D: begin
        if (mem_gnt) mem_req_d = 1'b0;
      end
      WAIT_I: begin
        if (!if_req) abort_d = 1'b1;
        tcnt_d = tcnt_q + TW'(1);
        if (mem_rvalid) begin
          if (fetch_live) begin
            if_rdata_d = mem_rdata;
            if_ready_d = 1'b1;
          end
        end else if (tmo) begin
          bus_err_d = 1'b1;
          if (fetch_live) begin
            if_rdata_d = '0;
            if_ready_d = 1'b1;
          end
        end
      end
      WAIT_D: begin
        tcnt_d = tcnt_q + TW'(1);
        if (mem_rvalid) begin
          dm_rdata_d = mem_we_q ? 32'h0 : mem_rdata;
          dm_ready_d = 1'b1;
        end else if (tmo) begin
          bus_err_d  = 1'b1;
          dm_rdata_d = '0;
          dm_ready_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign bus_err   = bus_err_q;
  assign stall_f   = if_req & ~if_ready_q;
  assign stall_m   = dm_req & ~dm_ready_q;

endmodule
